// File: rtl/vault_lockout_ctrl.sv
// vault_lockout_ctrl: attempt supervisor enforcing lockout, unlock window and alarm after a phase-3 sequence FSM.
// Optional macro VAULT_ALARM_LATCH_EN makes ALARM sticky until admin_clear; otherwise ALARM self-clears.
module vault_lockout_ctrl #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int CNT_W          = 3,
    parameter int TIMER_W        = 16,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int UNLOCK_CYCLES  = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             phase3_done,
    input  logic             phase3_fail,
    input  logic             admin_clear,
    output logic             phase_reset,
    output logic             unlock,
    output logic             alarm,
    output logic             locked_out,
    output logic [CNT_W-1:0] attempts
);
    typedef enum logic [2:0] {ARMED, LOCKOUT, RESTART, UNLOCKED, ALARM} state_t;
    localparam logic [TIMER_W-1:0] LOCK_T = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] UNL_T  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   MAX_C  = CNT_W'(MAX_ATTEMPTS);
    state_t             state, state_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic [CNT_W-1:0]   attempts_nx, att_inc;
    logic               timer_zero;
    assign att_inc    = (attempts == MAX_C) ? attempts : attempts + CNT_W'(1);
    assign timer_zero = (timer == '0);
    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        attempts_nx = attempts;
        case (state)
            ARMED: begin
                if (phase3_fail) begin
                    attempts_nx = att_inc;
                    state_nx    = (att_inc == MAX_C) ? ALARM : LOCKOUT;
                    timer_nx    = LOCK_T;
                end else if (phase3_done) begin
                    state_nx    = UNLOCKED;
                    timer_nx    = UNL_T;
                    attempts_nx = '0;
                end else if (admin_clear) begin
                    attempts_nx = '0;
                end
            end
            LOCKOUT: begin
                if (admin_clear) begin
                    state_nx    = RESTART;
                    attempts_nx = '0;
                end else begin
                    state_nx = timer_zero ? RESTART : LOCKOUT;
                    timer_nx = timer_zero ? timer : timer - TIMER_W'(1);
                end
            end
            RESTART: state_nx = ARMED;
            UNLOCKED: begin
                state_nx = timer_zero ? RESTART : UNLOCKED;
                timer_nx = timer_zero ? timer : timer - TIMER_W'(1);
            end
            ALARM: begin
                if (admin_clear) begin
                    state_nx    = RESTART;
                    attempts_nx = '0;
                end
`ifndef VAULT_ALARM_LATCH_EN
                else if (timer_zero) begin
                    state_nx    = RESTART;
                    attempts_nx = '0;
                end else begin
                    timer_nx = timer - TIMER_W'(1);
                end
`endif
            end
            default: state_nx = ARMED;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARMED;
            timer    <= '0;
            attempts <= '0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            attempts <= attempts_nx;
        end
    end
    assign phase_reset = (state == RESTART);
    assign unlock      = (state == UNLOCKED);
    assign alarm       = (state == ALARM);
    assign locked_out  = (state == LOCKOUT) || (state == ALARM);
endmodule

// File: tb/tb_vault_lockout_ctrl.sv
// tb_vault_lockout_ctrl: directed scoreboard bench for vault_lockout_ctrl (MAX=3, LOCKOUT=8, UNLOCK=5).
module tb_vault_lockout_ctrl;
    logic       clk = 0, reset_n = 0;
    logic       phase3_done = 0, phase3_fail = 0, admin_clear = 0;
    logic       phase_reset, unlock, alarm, locked_out;
    logic [2:0] attempts;
    int         n_cmp = 0, n_bad = 0;
    logic [6:0] exp_q[$];
    string      tag_q[$];

    vault_lockout_ctrl #(.MAX_ATTEMPTS(3), .CNT_W(3), .TIMER_W(16),
                         .LOCKOUT_CYCLES(8), .UNLOCK_CYCLES(5)) dut (
        .clk(clk), .reset_n(reset_n), .phase3_done(phase3_done), .phase3_fail(phase3_fail),
        .admin_clear(admin_clear), .phase_reset(phase_reset), .unlock(unlock), .alarm(alarm),
        .locked_out(locked_out), .attempts(attempts));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] e_of(input logic pr, un, al, lo, input logic [2:0] att);
        return {pr, un, al, lo, att};
    endfunction

    task automatic check();
        logic [6:0] e, obs;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        obs = {phase_reset, unlock, alarm, locked_out, attempts};
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: observed pr/un/al/lo/att=%b expected %b", t, obs, e);
        end
    endtask

    task automatic chk_now(input string tag, input logic [6:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check();
    endtask

    task automatic cyc(input string tag, input logic f, d, a, input logic [6:0] e);
        phase3_fail = f;
        phase3_done = d;
        admin_clear = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check();
    endtask

    // failure entering LOCKOUT, then the full 8-cycle dwell, the re-arm pulse and ARMED
    task automatic fail_seq(input string tag, input logic d, a, input logic [2:0] att);
        cyc(tag, 1, d, a, e_of(0, 0, 0, 1, att));
        for (int i = 0; i < 7; i++) cyc({tag, "_hold"}, 1, 0, 0, e_of(0, 0, 0, 1, att));
        cyc({tag, "_restart"}, 1, 0, 0, e_of(1, 0, 0, 0, att));
        cyc({tag, "_armed"}, 0, 0, 0, e_of(0, 0, 0, 0, att));
    endtask

    initial begin
        #12;
        chk_now("reset", e_of(0, 0, 0, 0, 0));
        reset_n = 1;
        @(posedge clk);
        #1;
        cyc("idle", 0, 0, 0, e_of(0, 0, 0, 0, 0));

        fail_seq("fail1", 0, 0, 1);
        cyc("no_recount", 0, 0, 0, e_of(0, 0, 0, 0, 1));

        cyc("done", 0, 1, 0, e_of(0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) cyc("unlock_hold", 0, 1, i[0], e_of(0, 1, 0, 0, 0));
        cyc("unlock_restart", 0, 1, 1, e_of(1, 0, 0, 0, 0));
        cyc("unlock_armed", 0, 0, 0, e_of(0, 0, 0, 0, 0));

        cyc("abort_enter", 1, 0, 0, e_of(0, 0, 0, 1, 1));
        cyc("abort_c2", 1, 0, 0, e_of(0, 0, 0, 1, 1));
        cyc("abort_c3", 1, 0, 0, e_of(0, 0, 0, 1, 1));
        cyc("abort_clear", 1, 0, 1, e_of(1, 0, 0, 0, 0));
        cyc("abort_armed", 0, 0, 0, e_of(0, 0, 0, 0, 0));

        fail_seq("fail_b", 0, 0, 1);
        cyc("armed_clear", 0, 0, 1, e_of(0, 0, 0, 0, 0));

        fail_seq("done_and_fail", 1, 0, 1);
        fail_seq("fail_and_clear", 0, 1, 2);
        cyc("alarm_enter", 1, 0, 0, e_of(0, 0, 1, 1, 3));
`ifdef VAULT_ALARM_LATCH_EN
        for (int i = 0; i < 120; i++) cyc("alarm_sticky", 1, 0, 0, e_of(0, 0, 1, 1, 3));
        cyc("alarm_clear", 1, 0, 1, e_of(1, 0, 0, 0, 0));
`else
        for (int i = 0; i < 7; i++) cyc("alarm_hold", 1, 0, 0, e_of(0, 0, 1, 1, 3));
        cyc("alarm_expire", 1, 0, 0, e_of(1, 0, 0, 0, 0));
`endif
        cyc("alarm_armed", 0, 0, 0, e_of(0, 0, 0, 0, 0));

        cyc("rst_enter", 1, 0, 0, e_of(0, 0, 0, 1, 1));
        cyc("rst_hold", 1, 0, 0, e_of(0, 0, 0, 1, 1));
        reset_n = 0;
        phase3_fail = 0;
        #2;
        chk_now("rst_async", e_of(0, 0, 0, 0, 0));
        #2;
        reset_n = 1;
        cyc("rst_armed", 0, 0, 0, e_of(0, 0, 0, 0, 0));
        cyc("rst_idle", 0, 0, 0, e_of(0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
